// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample sequencer.
// Also holds the axis conversion applied when a frame completes.
package accel_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WAIT} state_t;

  localparam int         FRAME_BYTES         = 6;
  localparam int         DEFAULT_TIMEOUT_CYC = 4096;

  localparam logic [2:0] IDX_XL = 3'd0;
  localparam logic [2:0] IDX_XH = 3'd1;
  localparam logic [2:0] IDX_YL = 3'd2;
  localparam logic [2:0] IDX_YH = 3'd3;
  localparam logic [2:0] IDX_ZL = 3'd4;
  localparam logic [2:0] IDX_ZH = 3'd5;

  // -32768 has no positive twin in 16 bits, so it saturates to 32767.
  function automatic logic [15:0] axis_value(input logic [7:0] lo, input logic [7:0] hi,
                                             input logic abs_en);
    logic [15:0] raw;
    raw = {hi, lo};
    if (!abs_en || !raw[15]) return raw;
    if (raw == 16'h8000) return 16'h7FFF;
    return ~raw + 16'd1;
  endfunction

endpackage

// File: rtl/accel_frame_assembler.sv
// Collects XL..ZH bytes into a frame and registers the three axis values
// at the moment the ZH byte is accepted.
module accel_frame_assembler
  import accel_pkg::*;
#(
  parameter bit ABS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        frame_start,
  output logic        frame_done,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z
);

  logic [2:0] idx;
  logic [7:0] frame_bytes [FRAME_BYTES];

  // A frame_start byte always resyncs, even when it lands in the ZH slot.
  assign frame_done = byte_valid && !frame_start && (idx == IDX_ZH);

  // Index 0 means no frame in progress, so stray bytes are dropped until a frame_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx     <= IDX_XL;
      accel_x <= '0;
      accel_y <= '0;
      accel_z <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) frame_bytes[i] <= '0;
    end else if (byte_valid) begin
      if (frame_start) begin
        frame_bytes[IDX_XL] <= byte_in;
        idx                 <= IDX_XH;
      end else if (idx == IDX_ZH) begin
        accel_x <= axis_value(frame_bytes[IDX_XL], frame_bytes[IDX_XH], ABS_EN);
        accel_y <= axis_value(frame_bytes[IDX_YL], frame_bytes[IDX_YH], ABS_EN);
        accel_z <= axis_value(frame_bytes[IDX_ZL], byte_in, ABS_EN);
        idx     <= IDX_XL;
      end else if (idx != IDX_XL) begin
        frame_bytes[idx] <= byte_in;
        idx              <= idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/accel_sample_sequencer.sv
// Accelerometer sample sequencer: frames sensor bytes into X/Y/Z, runs the
// magnitude calculator handshake with a timeout and forwards its result.
module accel_sample_sequencer
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter bit ABS_EN      = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             frame_start,
  output logic [15:0]      accel_x,
  output logic [15:0]      accel_y,
  output logic [15:0]      accel_z,
  output logic             start,
  input  logic [15:0]      magnitude,
  input  logic             valid,
  output logic [15:0]      mag_out,
  output logic             mag_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_count
);

  state_t      state;
  logic [31:0] timer;
  logic        frame_done;
  logic        take_byte;
  logic        expired;

  // Bytes arriving while a magnitude is outstanding never reach the assembler.
  assign take_byte = byte_valid && !busy;
  assign expired   = (TIMEOUT_CYC != 0) && (timer + 32'd1 == 32'(TIMEOUT_CYC));

  accel_frame_assembler #(
    .ABS_EN(ABS_EN)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (take_byte),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_z    (accel_z)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      mag_out      <= '0;
      mag_valid    <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      sample_count <= '0;
    end else begin
      start     <= 1'b0;
      mag_valid <= 1'b0;
      if (busy && byte_valid) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (take_byte && frame_start) state <= COLLECT;
        end
        COLLECT: begin
          if (frame_done) begin
            state <= ISSUE;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle is still accepted.
          if (valid) begin
            mag_out      <= magnitude;
            mag_valid    <= 1'b1;
            sample_count <= sample_count + CNT_W'(1);
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Testbench for accel_sample_sequencer: two instances (abs and raw axis modes)
// share one stimulus stream and are compared against a behavioural model.
module tb_accel_sample_sequencer;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        frame_start;
  logic        valid;
  logic [15:0] magnitude;

  logic [15:0] ax_a, ay_a, az_a, mag_out_a, count_a;
  logic        start_a, mag_valid_a, busy_a, overrun_a, timeout_a;
  logic [15:0] ax_r, ay_r, az_r, mag_out_r;
  logic [2:0]  count_r;
  logic        start_r, mag_valid_r, busy_r, overrun_r, timeout_r;

  logic [9:0]  status;
  logic [47:0] axes_a, axes_r;
  logic [18:0] count_obs;
  logic [31:0] mag_obs;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_count;
  bit          exp_overrun, exp_timeout;
  logic [15:0] exp_mag;

  always #5 clk = ~clk;

  accel_sample_sequencer #(.TIMEOUT_CYC(TMO), .ABS_EN(1'b1), .CNT_W(16)) dut_abs (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_start(frame_start), .accel_x(ax_a), .accel_y(ay_a), .accel_z(az_a),
    .start(start_a), .magnitude(magnitude), .valid(valid), .mag_out(mag_out_a),
    .mag_valid(mag_valid_a), .busy(busy_a), .overrun(overrun_a),
    .timeout_err(timeout_a), .sample_count(count_a)
  );

  accel_sample_sequencer #(.TIMEOUT_CYC(TMO), .ABS_EN(1'b0), .CNT_W(3)) dut_raw (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_start(frame_start), .accel_x(ax_r), .accel_y(ay_r), .accel_z(az_r),
    .start(start_r), .magnitude(magnitude), .valid(valid), .mag_out(mag_out_r),
    .mag_valid(mag_valid_r), .busy(busy_r), .overrun(overrun_r),
    .timeout_err(timeout_r), .sample_count(count_r)
  );

  assign status    = {start_a, busy_a, mag_valid_a, overrun_a, timeout_a,
                      start_r, busy_r, mag_valid_r, overrun_r, timeout_r};
  assign axes_a    = {ax_a, ay_a, az_a};
  assign axes_r    = {ax_r, ay_r, az_r};
  assign count_obs = {count_a, count_r};
  assign mag_obs   = {mag_out_a, mag_out_r};

  // Signed value from two bytes, optionally folded to magnitude and clipped.
  function automatic logic [15:0] model_axis(input logic [7:0] lo, input logic [7:0] hi,
                                             input bit abs_en);
    logic signed [15:0] s;
    int v;
    s = {hi, lo};
    v = s;
    if (abs_en && v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v[15:0];
  endfunction

  function automatic logic [47:0] model_axes(input logic [47:0] f, input bit abs_en);
    return {model_axis(f[7:0],   f[15:8],  abs_en),
            model_axis(f[23:16], f[31:24], abs_en),
            model_axis(f[39:32], f[47:40], abs_en)};
  endfunction

  function automatic logic [9:0] exp_status(input logic s, input logic b, input logic m);
    logic [4:0] one;
    one = {s, b, m, exp_overrun, exp_timeout};
    return {one, one};
  endfunction

  function automatic logic [18:0] exp_counts();
    logic [31:0] c;
    c = exp_count;
    return {c[15:0], c[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_byte(input logic [7:0] b, input logic fs);
    byte_in     = b;
    byte_valid  = 1'b1;
    frame_start = fs;
    tick();
    byte_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) put_byte(f[8*i +: 8], i == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; byte_in = '0; byte_valid = 1'b0; frame_start = 1'b0;
    valid = 1'b0; magnitude = '0;
    exp_count = 0; exp_overrun = 1'b0; exp_timeout = 1'b0; exp_mag = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_vec++;
    if (status !== exp_status(0, 0, 0)) begin
      n_err++; $display("[TB] FAIL reset_status got=%b exp=%b", status, exp_status(0, 0, 0));
    end
    n_vec++;
    if ({axes_a, axes_r} !== 96'd0) begin
      n_err++; $display("[TB] FAIL reset_axes got=%h exp=0", {axes_a, axes_r});
    end
    n_vec++;
    if ({count_obs, mag_obs} !== {exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL reset_count_mag got=%h exp=%h", {count_obs, mag_obs},
                        {exp_counts(), exp_mag, exp_mag});
    end
  endtask

  task automatic test_basic();
    logic [47:0] f;
    f = 48'h0064_FFF6_0010;
    put_byte(8'h5A, 1'b0);
    put_byte(8'hA5, 1'b0);
    n_vec++;
    if (status !== exp_status(0, 0, 0)) begin
      n_err++; $display("[TB] FAIL basic_idle_ignore got=%b exp=%b", status, exp_status(0, 0, 0));
    end
    send_frame(f);
    n_vec++;
    if (status !== exp_status(1, 1, 0)) begin
      n_err++; $display("[TB] FAIL basic_start got=%b exp=%b", status, exp_status(1, 1, 0));
    end
    n_vec++;
    if ({axes_a, axes_r} !== {model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
      n_err++; $display("[TB] FAIL basic_axes got=%h exp=%h", {axes_a, axes_r},
                        {model_axes(f, 1'b1), model_axes(f, 1'b0)});
    end
    tick();
    n_vec++;
    if (status !== exp_status(0, 1, 0)) begin
      n_err++; $display("[TB] FAIL basic_start_pulse got=%b exp=%b", status, exp_status(0, 1, 0));
    end
    repeat (4) tick();
    valid = 1'b1; magnitude = 16'h0066;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'h0066;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL basic_result got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag});
    end
    tick();
    n_vec++;
    if (status !== exp_status(0, 0, 0)) begin
      n_err++; $display("[TB] FAIL basic_mag_valid_pulse got=%b exp=%b", status, exp_status(0, 0, 0));
    end
  endtask

  task automatic test_saturate();
    logic [47:0] f;
    f = 48'h7FFF_8000_8001;
    send_frame(f);
    n_vec++;
    if ({axes_a, axes_r} !== {model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
      n_err++; $display("[TB] FAIL sat_axes got=%h exp=%h", {axes_a, axes_r},
                        {model_axes(f, 1'b1), model_axes(f, 1'b0)});
    end
    valid = 1'b1; magnitude = 16'h1111;
    tick();
    n_vec++;
    if (status !== exp_status(0, 1, 0)) begin
      n_err++; $display("[TB] FAIL sat_valid_in_issue got=%b exp=%b", status, exp_status(0, 1, 0));
    end
    magnitude = 16'hBEEF;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'hBEEF;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL sat_result got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag});
    end
    tick();
  endtask

  task automatic test_resync();
    logic [47:0] f;
    f = 48'h0003_0002_0001;
    put_byte(8'hAA, 1'b1);
    for (int i = 0; i < 4; i++) put_byte(8'hBB + 8'(i), 1'b0);
    put_byte(f[7:0], 1'b1);
    n_vec++;
    if (status !== exp_status(0, 0, 0)) begin
      n_err++; $display("[TB] FAIL resync_no_start got=%b exp=%b", status, exp_status(0, 0, 0));
    end
    for (int i = 1; i < 6; i++) put_byte(f[8*i +: 8], 1'b0);
    n_vec++;
    if ({status, axes_a, axes_r} !== {exp_status(1, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
      n_err++; $display("[TB] FAIL resync_frame got=%h exp=%h", {status, axes_a, axes_r},
                        {exp_status(1, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)});
    end
    tick(); tick();
    valid = 1'b1; magnitude = 16'h0004;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'h0004;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL resync_result got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag});
    end
    tick();
  endtask

  task automatic test_valid_at_expiry();
    send_frame(48'h1234_5678_9ABC);
    repeat (TMO) tick();
    n_vec++;
    if (status !== exp_status(0, 1, 0)) begin
      n_err++; $display("[TB] FAIL expiry_still_busy got=%b exp=%b", status, exp_status(0, 1, 0));
    end
    valid = 1'b1; magnitude = 16'h1234;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'h1234;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL expiry_valid_wins got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag});
    end
    tick();
  endtask

  task automatic test_timeout();
    send_frame(48'h0001_0002_0003);
    repeat (TMO) tick();
    n_vec++;
    if (status !== exp_status(0, 1, 0)) begin
      n_err++; $display("[TB] FAIL timeout_early got=%b exp=%b", status, exp_status(0, 1, 0));
    end
    tick();
    exp_timeout = 1'b1;
    n_vec++;
    if ({status, count_obs} !== {exp_status(0, 0, 0), exp_counts()}) begin
      n_err++; $display("[TB] FAIL timeout_flag got=%h exp=%h", {status, count_obs},
                        {exp_status(0, 0, 0), exp_counts()});
    end
    valid = 1'b1; magnitude = 16'hDEAD;
    tick();
    valid = 1'b0;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 0), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL timeout_valid_in_idle got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 0), exp_counts(), exp_mag, exp_mag});
    end
  endtask

  task automatic test_overrun();
    logic [47:0] f;
    f = 48'hFF00_0100_FFFF;
    send_frame(f);
    tick();
    put_byte(8'h77, 1'b1);
    exp_overrun = 1'b1;
    n_vec++;
    if ({status, axes_a, axes_r} !== {exp_status(0, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
      n_err++; $display("[TB] FAIL overrun_set got=%h exp=%h", {status, axes_a, axes_r},
                        {exp_status(0, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)});
    end
    put_byte(8'h88, 1'b0);
    valid = 1'b1; magnitude = 16'h0ABC;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'h0ABC;
    n_vec++;
    if ({status, count_obs, mag_obs} !== {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL overrun_result got=%h exp=%h", {status, count_obs, mag_obs},
                        {exp_status(0, 0, 1), exp_counts(), exp_mag, exp_mag});
    end
    for (int i = 0; i < 4; i++) put_byte(8'h40 + 8'(i), 1'b0);
    n_vec++;
    if ({status, axes_a, axes_r} !== {exp_status(0, 0, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
      n_err++; $display("[TB] FAIL overrun_dropped got=%h exp=%h", {status, axes_a, axes_r},
                        {exp_status(0, 0, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)});
    end
  endtask

  task automatic test_reset_in_wait();
    logic [47:0] f;
    f = 48'h0200_FE00_0100;
    send_frame(48'h1111_2222_3333);
    tick(); tick();
    reset = 1'b1;
    exp_count = 0; exp_overrun = 1'b0; exp_timeout = 1'b0; exp_mag = '0;
    #1;
    n_vec++;
    if ({status, axes_a, axes_r, count_obs, mag_obs} !== {exp_status(0, 0, 0), 96'd0, exp_counts(), 32'd0}) begin
      n_err++; $display("[TB] FAIL reset_wait_async got=%h exp=%h", {status, axes_a, axes_r, count_obs, mag_obs},
                        {exp_status(0, 0, 0), 96'd0, exp_counts(), 32'd0});
    end
    tick();
    reset = 1'b0;
    tick();
    put_byte(8'h10, 1'b1);
    put_byte(8'h20, 1'b0);
    put_byte(8'h30, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) put_byte(8'h50 + 8'(i), 1'b0);
    n_vec++;
    if ({status, axes_a, axes_r} !== {exp_status(0, 0, 0), 96'd0}) begin
      n_err++; $display("[TB] FAIL reset_partial_discard got=%h exp=%h", {status, axes_a, axes_r},
                        {exp_status(0, 0, 0), 96'd0});
    end
    send_frame(f);
    tick(); tick();
    valid = 1'b1; magnitude = 16'h0003;
    tick();
    valid = 1'b0;
    exp_count++; exp_mag = 16'h0003;
    n_vec++;
    if ({status, axes_a, axes_r, count_obs, mag_obs} !==
        {exp_status(0, 0, 1), model_axes(f, 1'b1), model_axes(f, 1'b0), exp_counts(), exp_mag, exp_mag}) begin
      n_err++; $display("[TB] FAIL reset_recover got=%h exp=%h", {status, axes_a, axes_r, count_obs, mag_obs},
                        {exp_status(0, 0, 1), model_axes(f, 1'b1), model_axes(f, 1'b0), exp_counts(), exp_mag, exp_mag});
    end
    tick();
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [47:0] f;
      logic [15:0] m;
      int          lat;
      int          fin;
      bit          ok;
      repeat ($urandom_range(0, 3)) put_byte(8'($urandom), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) put_byte(8'($urandom), i == 0);
      end
      f = {16'($urandom), 32'($urandom)};
      for (int a = 0; a < 3; a++) if ($urandom_range(0, 3) == 0) f[16*a +: 16] = 16'h8000;
      lat = $urandom_range(1, TMO + 3);
      m   = 16'($urandom);
      fin = (lat <= TMO) ? lat : TMO;
      ok  = (lat <= TMO);
      send_frame(f);
      n_vec++;
      if ({status, axes_a, axes_r} !== {exp_status(1, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)}) begin
        n_err++; $display("[TB] FAIL rand_issue it=%0d got=%h exp=%h", it, {status, axes_a, axes_r},
                          {exp_status(1, 1, 0), model_axes(f, 1'b1), model_axes(f, 1'b0)});
      end
      for (int k = 0; k <= fin; k++) begin
        bit inj;
        inj = ($urandom_range(0, 5) == 0);
        if (inj) begin
          byte_in = 8'($urandom); byte_valid = 1'b1; frame_start = 1'($urandom_range(0, 1));
        end
        if (k == lat) begin
          valid = 1'b1; magnitude = m;
        end
        tick();
        byte_valid = 1'b0; frame_start = 1'b0; valid = 1'b0;
        if (inj) exp_overrun = 1'b1;
        if (k < fin) begin
          n_vec++;
          if (status !== exp_status(0, 1, 0)) begin
            n_err++; $display("[TB] FAIL rand_wait it=%0d k=%0d got=%b exp=%b", it, k, status, exp_status(0, 1, 0));
          end
        end
      end
      if (ok) begin
        exp_count++; exp_mag = m;
      end else begin
        exp_timeout = 1'b1;
      end
      n_vec++;
      if ({status, axes_a, axes_r, count_obs, mag_obs} !==
          {exp_status(0, 0, ok), model_axes(f, 1'b1), model_axes(f, 1'b0), exp_counts(), exp_mag, exp_mag}) begin
        n_err++; $display("[TB] FAIL rand_result it=%0d lat=%0d got=%h exp=%h", it, lat,
                          {status, axes_a, axes_r, count_obs, mag_obs},
                          {exp_status(0, 0, ok), model_axes(f, 1'b1), model_axes(f, 1'b0), exp_counts(), exp_mag, exp_mag});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_resync();
    test_valid_at_expiry();
    test_timeout();
    test_overrun();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not complete got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
